// File: rtl/uart_tx_fifo_pkg.sv
// Shared types for the FIFO-draining UART transmitter.
// Parity support is compiled in with UART_TX_PARITY_EN.
package uart_tx_fifo_pkg;

    typedef logic [7:0] data_t;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } tx_state_e;

`ifdef UART_TX_PARITY_EN
    function automatic logic parity_of(input data_t d, input logic odd);
        return (^d) ^ odd;
    endfunction
`endif

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Read port of a show-ahead FIFO as seen by its consumer.
// master = FIFO side, slave = transmitter side.
interface uart_tx_fifo_if;
    import uart_tx_fifo_pkg::*;

    logic  fifo_empty;
    data_t fifo_data;
    logic  fifo_en;

    modport master (
        output fifo_empty,
        output fifo_data,
        input  fifo_en
    );

    modport slave (
        input  fifo_empty,
        input  fifo_data,
        output fifo_en
    );

endinterface

// File: rtl/uart_tx_fifo_baud_tick.sv
// Free-running bit-time down-counter; tick marks the last cycle of a bit.
// clear restarts a full bit period on the following cycle.
module uart_tx_fifo_baud_tick #(
    parameter int DIV = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TOP = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || cnt == '0) begin
            cnt <= TOP;
        end else begin
            cnt <= cnt - W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter draining a show-ahead FIFO, LSB-first 8-bit frames.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int BAUD_DIV   = 868,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    uart_tx_fifo_if.slave      fifo,
    output logic               tx,
    output logic               busy,
    output logic [15:0]        frame_count
);

    if (BAUD_DIV < 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_err
        $error("uart_tx_fifo: unsupported parameter set");
    end

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
    localparam tx_state_e AFTER_DATA = S_PARITY;
`else
    localparam tx_state_e AFTER_DATA = S_STOP;
`endif

    tx_state_e  state;
    tx_state_e  state_nx;
    data_t      shreg;
    logic [2:0] bit_cnt;
    logic       stop_cnt;
    logic       tick;
    logic       pop;
    logic       start_ok;
    logic       stop_last;
`ifdef UART_TX_PARITY_EN
    logic       par_bit;
`endif

    assign start_ok  = en && !fifo.fifo_empty;
    assign stop_last = (STOP_BITS == 1) || stop_cnt;

    uart_tx_fifo_baud_tick #(
        .DIV(BAUD_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(pop),
        .tick (tick)
    );

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_ok) begin
                    pop      = 1'b1;
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (tick) state_nx = S_DATA;
            end
            S_DATA: begin
                if (tick && bit_cnt == LAST_BIT) state_nx = AFTER_DATA;
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick) state_nx = S_STOP;
            end
`endif
            S_STOP: begin
                if (tick && stop_last) begin
                    if (start_ok) begin
                        pop      = 1'b1;
                        state_nx = S_START;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // Reset wins over any start opportunity in the same cycle
        if (rst) begin
            pop      = 1'b0;
            state_nx = S_IDLE;
        end
    end

    always_comb begin
        tx = 1'b1;
        unique case (state)
            S_START:  tx = 1'b0;
            S_DATA:   tx = shreg[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx = par_bit;
`endif
            default:  tx = 1'b1;
        endcase
    end

    assign busy         = (state != S_IDLE);
    assign fifo.fifo_en = pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            frame_count <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit     <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            if (pop) begin
                shreg       <= fifo.fifo_data;
                bit_cnt     <= '0;
                stop_cnt    <= 1'b0;
                frame_count <= frame_count + 16'd1;
`ifdef UART_TX_PARITY_EN
                par_bit     <= parity_of(fifo.fifo_data, PARITY_ODD != 0);
`endif
            end else if (tick) begin
                if (state == S_DATA) begin
                    shreg   <= shreg >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (state == S_STOP) begin
                    stop_cnt <= ~stop_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: FIFO model, frame scoreboard,
// vector table and hand-written corner sequences.
module tb_uart_tx_fifo;

    localparam int DIV_A  = 4;
    localparam int DIV_B  = 2;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NB_A = 9 + PB + 1;
    localparam int NB_B = 9 + PB + 2;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_a = 1'b1;
    logic        en_b = 1'b1;
    logic        tx_a, busy_a, tx_b, busy_b;
    logic [15:0] fc_a, fc_b;

    uart_tx_fifo_if fa();
    uart_tx_fifo_if fb();

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .BAUD_DIV(DIV_A), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .fifo(fa),
        .tx(tx_a), .busy(busy_a), .frame_count(fc_a)
    );

    uart_tx_fifo #(
        .BAUD_DIV(DIV_B), .STOP_BITS(2), .PARITY_ODD(1)
    ) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .fifo(fb),
        .tx(tx_b), .busy(busy_b), .frame_count(fc_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [11:0] sb[$];
    int          pops_a = 0;
    int          pops_b = 0;

    logic        s_tx_a, s_busy_a, s_en_a;
    logic        s_tx_b, s_busy_b, s_en_b;
    logic [15:0] s_fc_a, s_fc_b;

    logic        mon_on = 1'b1;
    logic [11:0] mon_got, mon_exp;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic logic [11:0] mk(input logic [7:0] d, input logic p);
        logic [11:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = d;
        f[9]   = (PB != 0) ? p : 1'b1;
        return f;
    endfunction

    function automatic void drive();
        fa.fifo_empty = (qa.size() == 0);
        fa.fifo_data  = (qa.size() != 0) ? qa[0] : 8'h00;
        fb.fifo_empty = (qb.size() == 0);
        fb.fifo_data  = (qb.size() != 0) ? qb[0] : 8'h00;
    endfunction

    // sample at negedge, then apply any pop and new FIFO head after posedge
    task automatic cyc();
        @(negedge clk);
        s_tx_a = tx_a;  s_busy_a = busy_a;  s_en_a = fa.fifo_en;  s_fc_a = fc_a;
        s_tx_b = tx_b;  s_busy_b = busy_b;  s_en_b = fb.fifo_en;  s_fc_b = fc_b;
        @(posedge clk);
        #1;
        if (s_en_a === 1'b1) begin
            if (qa.size() != 0) void'(qa.pop_front());
            pops_a++;
        end
        if (s_en_b === 1'b1) begin
            if (qb.size() != 0) void'(qb.pop_front());
            pops_b++;
        end
        drive();
    endtask

    task automatic push_a(input logic [7:0] d, input logic p);
        qa.push_back(d);
        sb.push_back(mk(d, p));
        drive();
    endtask

    task automatic wait_idle_a(input string tag);
        int k;
        k = 0;
        do begin
            cyc();
            k++;
        end while ((s_busy_a || s_en_a) && k < 400);
        check({tag, "_idle"}, 32'(s_busy_a), 32'd0);
    endtask

    always begin
        @(negedge clk);
        if (mon_on && tx_a === 1'b0) begin
            mon_got    = '1;
            mon_got[0] = 1'b0;
            for (int i = 1; i < NB_A; i++) begin
                repeat (DIV_A) @(negedge clk);
                mon_got[i] = tx_a;
            end
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: got frame %h, none expected", mon_got);
            end else begin
                mon_exp = sb.pop_front();
                check("frame", 32'(mon_got), 32'(mon_exp));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt[6];
        logic [11:0] f;
        int          p0, busy_n, extra, pop_at, errs, fc_exp;

        vt[0] = '{d: 8'h00, p: 1'b0};
        vt[1] = '{d: 8'hFF, p: 1'b0};
        vt[2] = '{d: 8'h07, p: 1'b1};
        vt[3] = '{d: 8'h80, p: 1'b1};
        vt[4] = '{d: 8'h3C, p: 1'b0};
        vt[5] = '{d: 8'h01, p: 1'b1};

        drive();
        rst = 1'b1;
        repeat (3) cyc();
        check("rst_tx_a",   32'(s_tx_a),   32'd1);
        check("rst_busy_a", 32'(s_busy_a), 32'd0);
        check("rst_pop_a",  32'(s_en_a),   32'd0);
        check("rst_fc_a",   32'(s_fc_a),   32'd0);
        check("rst_tx_b",   32'(s_tx_b),   32'd1);
        check("rst_busy_b", 32'(s_busy_b), 32'd0);
        rst = 1'b0;
        cyc();
        fc_exp = 0;

        // single 0xA5 frame, cycle exact
        p0 = pops_a;
        push_a(8'hA5, 1'b0);
        cyc();
        fc_exp++;
        check("a5_pop", 32'(s_en_a), 32'd1);
        check("a5_pop_tx", 32'(s_tx_a), 32'd1);
        f = mk(8'hA5, 1'b0);
        busy_n = 0;
        extra  = 0;
        for (int i = 0; i < NB_A * DIV_A; i++) begin
            cyc();
            if (s_busy_a) busy_n++;
            if (s_en_a) extra++;
            if (i % DIV_A == 0)
                check($sformatf("a5_bit%0d", i / DIV_A), 32'(s_tx_a), 32'(f[i / DIV_A]));
        end
        cyc();
        check("a5_busy_cycles", busy_n, NB_A * DIV_A);
        check("a5_extra_pops", extra, 0);
        check("a5_busy_end", 32'(s_busy_a), 32'd0);
        check("a5_pops", pops_a - p0, 1);
        check("a5_fc", 32'(s_fc_a), 32'(fc_exp));

        // back-to-back 0x00, 0xFF
        p0 = pops_a;
        push_a(8'h00, 1'b0);
        push_a(8'hFF, 1'b0);
        cyc();
        fc_exp += 2;
        busy_n = 0;
        pop_at = -1;
        for (int i = 0; i < 300; i++) begin
            cyc();
            if (!s_busy_a) break;
            busy_n++;
            if (s_en_a) pop_at = busy_n;
        end
        check("b2b_busy_cycles", busy_n, 2 * NB_A * DIV_A);
        check("b2b_pop_at", pop_at, NB_A * DIV_A);
        check("b2b_pops", pops_a - p0, 2);
        check("b2b_fc", 32'(s_fc_a), 32'(fc_exp));

        // vector table
        foreach (vt[i]) begin
            p0 = pops_a;
            push_a(vt[i].d, vt[i].p);
            wait_idle_a($sformatf("vec%0d", i));
            fc_exp++;
            check($sformatf("vec%0d_pops", i), pops_a - p0, 1);
            check($sformatf("vec%0d_fc", i), 32'(s_fc_a), 32'(fc_exp));
        end

        // en low holds the FIFO head
        en_a = 1'b0;
        p0 = pops_a;
        push_a(8'h55, 1'b0);
        errs = 0;
        repeat (10) begin
            cyc();
            if (s_en_a || !s_tx_a || s_busy_a) errs++;
        end
        check("en_low_hold", errs, 0);
        en_a = 1'b1;
        cyc();
        check("en_rise_pop", 32'(s_en_a), 32'd1);
        cyc();
        check("en_rise_start", 32'(s_tx_a), 32'd0);
        wait_idle_a("en_rise");
        fc_exp++;
        check("en_rise_pops", pops_a - p0, 1);

        // en dropped exactly on the last stop cycle
        p0 = pops_a;
        push_a(8'h96, 1'b0);
        push_a(8'h5A, 1'b0);
        cyc();
        fc_exp++;
        repeat (NB_A * DIV_A - 1) cyc();
        en_a = 1'b0;
        cyc();
        check("stop_last_nopop", 32'(s_en_a), 32'd0);
        check("stop_last_busy", 32'(s_busy_a), 32'd1);
        cyc();
        check("stop_last_idle", 32'(s_busy_a), 32'd0);
        repeat (3) cyc();
        check("stop_last_pops", pops_a - p0, 1);
        en_a = 1'b1;
        wait_idle_a("stop_last");
        fc_exp++;
        check("stop_last_pops2", pops_a - p0, 2);
        check("stop_last_fc", 32'(s_fc_a), 32'(fc_exp));

        // reset in data bit 3, held into an idle start opportunity
        mon_on = 1'b0;
        push_a(8'hC3, 1'b0);
        push_a(8'h69, 1'b0);
        cyc();
        repeat (4 * DIV_A + 2) cyc();
        rst = 1'b1;
        p0 = pops_a;
        cyc();
        check("rst_mid_nopop", 32'(s_en_a), 32'd0);
        cyc();
        check("rst_prio_nopop", 32'(s_en_a), 32'd0);
        check("rst_mid_tx", 32'(s_tx_a), 32'd1);
        check("rst_mid_busy", 32'(s_busy_a), 32'd0);
        check("rst_mid_fc", 32'(s_fc_a), 32'd0);
        rst = 1'b0;
        void'(sb.pop_front());
        mon_on = 1'b1;
        cyc();
        check("rst_restart_pop", 32'(s_en_a), 32'd1);
        check("rst_restart_fc0", 32'(s_fc_a), 32'd0);
        wait_idle_a("rst_restart");
        check("rst_pops", pops_a - p0, 1);
        check("rst_restart_fc", 32'(s_fc_a), 32'd1);

        // two stop bits at BAUD_DIV=2, odd parity if compiled in
        p0 = pops_b;
        qb.push_back(8'h07);
        drive();
        cyc();
        check("b_pop", 32'(s_en_b), 32'd1);
        f = mk(8'h07, 1'b0);
        busy_n = 0;
        errs = 0;
        for (int i = 0; i < NB_B * DIV_B; i++) begin
            cyc();
            if (s_busy_b) busy_n++;
            if (s_en_b) errs++;
            if (s_tx_b !== f[i / DIV_B]) errs++;
        end
        check("b_tx_cycles", errs, 0);
        check("b_busy_cycles", busy_n, NB_B * DIV_B);
        cyc();
        check("b_idle", 32'(s_busy_b), 32'd0);
        repeat (5) cyc();
        check("b_pops", pops_b - p0, 1);
        check("b_fc", 32'(s_fc_b), 32'd1);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
